// File: rtl/dcache_store_load_arbiter_if.sv
// dcache_store_load_arbiter_if: load, store-buffer, fence and D$ port signals of the arbiter.
// The master modport is the arbiter itself; the slave modport is its environment.
interface dcache_store_load_arbiter_if;
    logic        ld_req_i;
    logic [63:0] ld_addr_i;
    logic [7:0]  ld_be_i;
    logic [1:0]  ld_size_i;
    logic        ld_gnt_o;
    logic        ld_rvalid_o;
    logic [63:0] ld_rdata_o;
    logic        st_req_i;
    logic [63:0] st_addr_i;
    logic [63:0] st_wdata_i;
    logic [7:0]  st_be_i;
    logic [1:0]  st_size_i;
    logic        st_gnt_o;
    logic        st_offset_match_i;
    logic        no_st_pending_i;
    logic        fence_i;
    logic        fence_done_o;
    logic        dc_req_o;
    logic        dc_we_o;
    logic [63:0] dc_addr_o;
    logic [63:0] dc_wdata_o;
    logic [7:0]  dc_be_o;
    logic [1:0]  dc_size_o;
    logic        dc_gnt_i;
    logic        dc_rvalid_i;
    logic [63:0] dc_rdata_i;

    modport master (
        input  ld_req_i, ld_addr_i, ld_be_i, ld_size_i,
        output ld_gnt_o, ld_rvalid_o, ld_rdata_o,
        input  st_req_i, st_addr_i, st_wdata_i, st_be_i, st_size_i, st_offset_match_i, no_st_pending_i,
        output st_gnt_o,
        input  fence_i,
        output fence_done_o,
        output dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_be_o, dc_size_o,
        input  dc_gnt_i, dc_rvalid_i, dc_rdata_i
    );

    modport slave (
        output ld_req_i, ld_addr_i, ld_be_i, ld_size_i,
        input  ld_gnt_o, ld_rvalid_o, ld_rdata_o,
        output st_req_i, st_addr_i, st_wdata_i, st_be_i, st_size_i, st_offset_match_i, no_st_pending_i,
        input  st_gnt_o,
        output fence_i,
        input  fence_done_o,
        input  dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_be_o, dc_size_o,
        output dc_gnt_i, dc_rvalid_i, dc_rdata_i
    );
endinterface

// File: rtl/dcache_store_load_arbiter.sv
// dcache_store_load_arbiter: shares the D$ request port between loads and committed stores,
// load-first with offset-hazard hold-off, starvation bursts and fence draining.
module dcache_store_load_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_LEN    = 2
) (
    input logic clk_i,
    input logic rst_i,
    dcache_store_load_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] B_MAX = BW'(BURST_LEN);

    typedef enum logic [1:0] {NORMAL, FORCE_ST, DRAIN} state_e;

    state_e          state_q, state_d;
    logic            lock_q, lock_d;
    logic            owner_st_q, owner_st_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            fence_done_q, fence_done_d;
    logic            lock_act, ld_ok, sel_ld, sel_st;

    // A lock only holds while its owner keeps requesting; a flushed load releases it.
    assign lock_act = lock_q & (owner_st_q ? bus.st_req_i : bus.ld_req_i);
    assign ld_ok    = bus.ld_req_i & ~bus.st_offset_match_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= NORMAL;
            lock_q       <= 1'b0;
            owner_st_q   <= 1'b0;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            fence_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            owner_st_q   <= owner_st_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            fence_done_q <= fence_done_d;
        end
    end

    always_comb begin
        lock_d       = bus.dc_req_o & ~bus.dc_gnt_i;
        owner_st_d   = sel_st;
        starve_cnt_d = bus.st_gnt_o ? '0 :
                       (bus.st_req_i && starve_cnt_q != S_MAX) ? starve_cnt_q + 1'b1 : starve_cnt_q;
        // Outside FORCE_ST the burst counter sits at zero, so entering FORCE_ST starts a fresh burst.
        burst_cnt_d  = (state_q == FORCE_ST) ? burst_cnt_q + BW'(bus.st_gnt_o) : '0;
        state_d      = state_q;
        fence_done_d = 1'b0;
        case (state_q)
            NORMAL:   state_d = bus.fence_i ? DRAIN : (starve_cnt_d == S_MAX) ? FORCE_ST : NORMAL;
            FORCE_ST: state_d = bus.fence_i ? DRAIN :
                                (burst_cnt_d == B_MAX || (!bus.st_req_i && !lock_act)) ? NORMAL : FORCE_ST;
            DRAIN: begin
                if (!bus.st_req_i && bus.no_st_pending_i && !lock_act) begin
                    state_d      = NORMAL;
                    fence_done_d = 1'b1;
                end
            end
            default:  state_d = NORMAL;
        endcase
    end

    always_comb begin
        sel_st           = lock_act ? owner_st_q : (state_q == NORMAL) ? (~ld_ok & bus.st_req_i) : bus.st_req_i;
        sel_ld           = lock_act ? ~owner_st_q :
                           ld_ok & ((state_q == NORMAL) | ((state_q == FORCE_ST) & ~bus.st_req_i));
        bus.dc_req_o     = sel_ld | sel_st;
        bus.dc_we_o      = sel_st;
        bus.dc_addr_o    = sel_st ? bus.st_addr_i : sel_ld ? bus.ld_addr_i : '0;
        bus.dc_wdata_o   = sel_st ? bus.st_wdata_i : '0;
        bus.dc_be_o      = sel_st ? bus.st_be_i : sel_ld ? bus.ld_be_i : '0;
        bus.dc_size_o    = sel_st ? bus.st_size_i : sel_ld ? bus.ld_size_i : '0;
        bus.ld_gnt_o     = bus.dc_gnt_i & sel_ld;
        bus.st_gnt_o     = bus.dc_gnt_i & sel_st;
        bus.ld_rvalid_o  = bus.dc_rvalid_i;
        bus.ld_rdata_o   = bus.dc_rdata_i;
        bus.fence_done_o = fence_done_q;
    end

    a_one_gnt: assert property (@(posedge clk_i) disable iff (rst_i) !(bus.ld_gnt_o && bus.st_gnt_o));
    a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i) lock_act |-> $stable(bus.dc_addr_o));
    a_no_ld_drain: assert property (@(posedge clk_i) disable iff (rst_i) !(state_q == DRAIN && sel_ld && !lock_act));
endmodule

// File: tb/tb_dcache_store_load_arbiter.sv
// tb_dcache_store_load_arbiter: directed and random stimulus against a cycle-level reference
// model; expected responses are queued per cycle and checked by an independent monitor.
module tb_dcache_store_load_arbiter;
    localparam int SL = 8;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_store_load_arbiter_if bus();
    dcache_store_load_arbiter #(.STARVE_LIMIT(SL), .BURST_LEN(BL)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        bit          chk;
        logic        dc_req, we, ld_gnt, st_gnt, fd, rvalid;
        logic [63:0] addr, wdata, rdata;
        logic [7:0]  be;
        logic [1:0]  size;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference model: mode 0=normal 1=forced stores 2=drain; owner -1=none 0=load 1=store.
    int mode, starve, burst, owner, sc;
    bit fd;

    task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                cmp("dc_req", bus.dc_req_o, e.dc_req);
                cmp("dc_we", bus.dc_we_o, e.we);
                cmp("dc_addr", bus.dc_addr_o, e.addr);
                cmp("dc_wdata", bus.dc_wdata_o, e.wdata);
                cmp("dc_be", bus.dc_be_o, e.be);
                cmp("dc_size", bus.dc_size_o, e.size);
                cmp("ld_gnt", bus.ld_gnt_o, e.ld_gnt);
                cmp("st_gnt", bus.st_gnt_o, e.st_gnt);
                cmp("fence_done", bus.fence_done_o, e.fd);
                cmp("ld_rvalid", bus.ld_rvalid_o, e.rvalid);
                cmp("ld_rdata", bus.ld_rdata_o, e.rdata);
            end
        end
    end

    task automatic new_ld();
        bus.ld_addr_i = {$urandom, $urandom};
        bus.ld_be_i   = 8'($urandom);
        bus.ld_size_i = 2'($urandom);
    endtask

    task automatic new_st();
        bus.st_addr_i  = {$urandom, $urandom};
        bus.st_wdata_i = {$urandom, $urandom};
        bus.st_be_i    = 8'($urandom);
        bus.st_size_i  = 2'($urandom);
    endtask

    // Predict this cycle's outputs from the applied inputs, queue them, then advance the model.
    task automatic step();
        exp_t e;
        int eff, sel;
        bit ld_ok, ld_g, st_g, lk;
        e = '{default: '0};
        if (rst) begin
            sb.push_back(e);
            @(posedge clk); #1;
            mode = 0; starve = 0; burst = 0; owner = -1; fd = 0;
            return;
        end
        ld_ok = bus.ld_req_i && !bus.st_offset_match_i;
        eff = (owner == 0 && bus.ld_req_i) ? 0 : (owner == 1 && bus.st_req_i) ? 1 : -1;
        if (eff >= 0) sel = eff;
        else if (mode == 2) sel = bus.st_req_i ? 1 : -1;
        else if (mode == 1) sel = bus.st_req_i ? 1 : ld_ok ? 0 : -1;
        else sel = ld_ok ? 0 : bus.st_req_i ? 1 : -1;
        ld_g = bus.dc_gnt_i && sel == 0;
        st_g = bus.dc_gnt_i && sel == 1;
        e.chk    = 1;
        e.dc_req = sel >= 0;
        e.we     = sel == 1;
        e.addr   = sel == 1 ? bus.st_addr_i : sel == 0 ? bus.ld_addr_i : 64'd0;
        e.wdata  = sel == 1 ? bus.st_wdata_i : 64'd0;
        e.be     = sel == 1 ? bus.st_be_i : sel == 0 ? bus.ld_be_i : 8'd0;
        e.size   = sel == 1 ? bus.st_size_i : sel == 0 ? bus.ld_size_i : 2'd0;
        e.ld_gnt = ld_g;
        e.st_gnt = st_g;
        e.fd     = fd;
        e.rvalid = bus.dc_rvalid_i;
        e.rdata  = bus.dc_rdata_i;
        sb.push_back(e);
        lk = eff >= 0;
        owner = (sel >= 0 && !bus.dc_gnt_i) ? sel : -1;
        if (st_g) starve = 0;
        else if (bus.st_req_i && starve < SL) starve++;
        fd = 0;
        if (mode == 0) begin
            if (bus.fence_i) mode = 2;
            else if (starve == SL) begin mode = 1; burst = 0; end
        end else if (mode == 1) begin
            burst += int'(st_g);
            if (bus.fence_i) mode = 2;
            else if (burst == BL || (!bus.st_req_i && !lk)) mode = 0;
        end else if (!bus.st_req_i && bus.no_st_pending_i && !lk) begin
            mode = 0;
            fd = 1;
        end
        @(posedge clk); #1;
        if (ld_g) new_ld();
        if (st_g) begin
            new_st();
            if (sc > 0) sc--;
        end
    endtask

    task automatic drv(input bit ld, input bit st, input bit m, input bit g, input bit f, input bit np);
        bus.ld_req_i = ld; bus.st_req_i = st; bus.st_offset_match_i = m;
        bus.dc_gnt_i = g; bus.fence_i = f; bus.no_st_pending_i = np;
        step();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        sc = 0;
        bus.dc_rvalid_i = 1'b0;
        bus.dc_rdata_i = '0;
        new_ld();
        new_st();
        drv(0, 0, 0, 0, 0, 1);
        rst = 1'b0;
    endtask

    task automatic rnd();
        if (owner == 0) begin
            bus.ld_req_i = $urandom_range(9) != 0;
            bus.st_offset_match_i = 1'b0;
        end else begin
            if ($urandom_range(2) == 0) new_ld();
            bus.ld_req_i = $urandom_range(2) != 0;
            bus.st_offset_match_i = bus.ld_req_i && $urandom_range(3) == 0;
        end
        if (sc < 6 && $urandom_range(3) == 0) sc++;
        bus.st_req_i        = sc > 0 && (owner == 1 || $urandom_range(7) != 0);
        bus.no_st_pending_i = sc == 0;
        bus.fence_i         = $urandom_range(39) == 0;
        bus.dc_gnt_i        = $urandom_range(3) != 0;
        bus.dc_rvalid_i     = 1'($urandom_range(1));
        bus.dc_rdata_i      = {$urandom, $urandom};
        rst                 = $urandom_range(499) == 0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        mode = 0; starve = 0; burst = 0; owner = -1; fd = 0; sc = 0;
        bus.ld_req_i = 0; bus.st_req_i = 0; bus.st_offset_match_i = 0; bus.fence_i = 0;
        bus.no_st_pending_i = 1; bus.dc_gnt_i = 0; bus.dc_rvalid_i = 0; bus.dc_rdata_i = '0;
        new_ld();
        new_st();
        @(posedge clk); #1;
        reset_dut();
        drv(0, 0, 0, 1, 0, 1);
        // load and store together: load first, store next cycle
        reset_dut();
        sc = 1;
        drv(1, 1, 0, 1, 0, 0);
        drv(0, 1, 0, 1, 0, 0);
        drv(0, 0, 0, 1, 0, 1);
        // offset hazard: stores drain, load waits for match to clear
        reset_dut();
        sc = 2;
        drv(1, 1, 1, 1, 0, 0);
        drv(1, 1, 1, 1, 0, 0);
        drv(1, 0, 0, 1, 0, 1);
        // starvation burst
        reset_dut();
        sc = 6;
        for (int i = 0; i < 14; i++) drv(1, 1, 0, 1, 0, 0);
        // locked store holds the port against a later load
        reset_dut();
        sc = 1;
        drv(0, 1, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0);
        drv(1, 1, 0, 1, 0, 0);
        drv(1, 0, 0, 1, 0, 1);
        // fence drains three stores before the held load
        reset_dut();
        sc = 3;
        drv(0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 6; i++) drv(1, sc > 0, 0, 1, 0, sc == 0);
        // reset in the middle of a locked store
        reset_dut();
        sc = 1;
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        drv(0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        sc = 0;
        drv(0, 0, 0, 1, 0, 1);
        // random traffic
        reset_dut();
        for (int i = 0; i < 3000; i++) rnd();
        rst = 1'b0;
        drv(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        cmp("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
